// File: rtl/bus_cycle_controller_pkg.sv
// Shared encodings for the Riley0 bus cycle controller: FSM states, region codes,
// master IDs, default wait states and the decoder-select priority function.
package bus_cycle_controller_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    localparam logic [1:0] REG_NONE = 2'd0;
    localparam logic [1:0] REG_RAM  = 2'd1;
    localparam logic [1:0] REG_ROM  = 2'd2;
    localparam logic [1:0] REG_IO   = 2'd3;

    localparam logic MST_CPU = 1'b0;
    localparam logic MST_DMA = 1'b1;

    localparam int DEF_RAM_WAIT = 0;
    localparam int DEF_ROM_WAIT = 1;
    localparam int DEF_IO_WAIT  = 2;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } bus_req_t;

    // Overlapping decoder windows resolve as io > rom > ram; nothing selected is unmapped.
    function automatic logic [1:0] decode_region(input logic ram_sel_n,
                                                 input logic rom_sel_n,
                                                 input logic io_sel_n);
        if (!io_sel_n)       return REG_IO;
        else if (!rom_sel_n) return REG_ROM;
        else if (!ram_sel_n) return REG_RAM;
        else                 return REG_NONE;
    endfunction

endpackage

// File: rtl/bus_cycle_controller_arbiter.sv
// Two-way round-robin arbiter between CPU and DMA. Grants are only offered while
// grant_en is high; the last winner loses the next tie.
module bus_cycle_controller_arbiter
    import bus_cycle_controller_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic cpu_req,
    input  logic dma_req,
    input  logic grant_en,
    output logic grant_cpu,
    output logic grant_dma
);

    logic r_last_grant;
    logic w_grant_cpu;
    logic w_grant_dma;

    assign w_grant_cpu = grant_en & cpu_req & (~dma_req | (r_last_grant == MST_DMA));
    assign w_grant_dma = grant_en & dma_req & (~cpu_req | (r_last_grant == MST_CPU));

    // Reset to DMA so the CPU wins the very first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= MST_DMA;
        end else if (w_grant_cpu) begin
            r_last_grant <= MST_CPU;
        end else if (w_grant_dma) begin
            r_last_grant <= MST_DMA;
        end
    end

    assign grant_cpu = w_grant_cpu;
    assign grant_dma = w_grant_dma;

endmodule

// File: rtl/bus_cycle_controller.sv
// Riley0 bus cycle controller: arbitrates CPU/DMA, runs IDLE->SETUP->ACCESS->HOLD
// with per-region wait states, drives chip selects/strobes and returns ack + read data.
module bus_cycle_controller
    import bus_cycle_controller_pkg::*;
#(
    parameter int RAM_WAIT = DEF_RAM_WAIT,
    parameter int ROM_WAIT = DEF_ROM_WAIT,
    parameter int IO_WAIT  = DEF_IO_WAIT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic [7:0]  dma_rdata,
    output logic        dma_ack,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    input  logic        ram_sel_n,
    input  logic        rom_sel_n,
    input  logic        io_sel_n,
    output logic        ram_cs_n,
    output logic        rom_cs_n,
    output logic        io_cs_n,
    output logic        bus_oe_n,
    output logic        bus_we_n,
    output logic        rom_wr_err,
    output logic [1:0]  dbg_state
);

    logic [1:0]  r_state;
    logic [1:0]  r_region;
    logic [2:0]  r_cnt;
    logic        r_master;
    logic        r_we;
    logic [15:0] r_bus_addr;
    logic [7:0]  r_bus_wdata;
    logic [7:0]  r_cpu_rdata;
    logic [7:0]  r_dma_rdata;
    logic        r_ram_cs_n;
    logic        r_rom_cs_n;
    logic        r_io_cs_n;
    logic        r_oe_n;
    logic        r_we_n;
    logic        r_cpu_ack;
    logic        r_dma_ack;
    logic        r_rom_wr_err;

    logic        w_grant_cpu;
    logic        w_grant_dma;
    logic        w_grant_any;
    logic [1:0]  w_region;
    logic [2:0]  w_wait;
    logic [7:0]  w_rd_val;
    bus_req_t    w_req;

    bus_cycle_controller_arbiter u_arbiter (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_req   (cpu_req),
        .dma_req   (dma_req),
        .grant_en  (r_state == ST_IDLE),
        .grant_cpu (w_grant_cpu),
        .grant_dma (w_grant_dma)
    );

    assign w_grant_any = w_grant_cpu | w_grant_dma;
    assign w_region    = decode_region(ram_sel_n, rom_sel_n, io_sel_n);
    assign w_rd_val    = (r_region == REG_NONE) ? 8'hFF : bus_rdata;

    always_comb begin
        w_req.we    = cpu_we;
        w_req.addr  = cpu_addr;
        w_req.wdata = cpu_wdata;
        if (w_grant_dma) begin
            w_req.we    = dma_we;
            w_req.addr  = dma_addr;
            w_req.wdata = dma_wdata;
        end
    end

    always_comb begin
        case (w_region)
            REG_RAM: w_wait = 3'(RAM_WAIT);
            REG_ROM: w_wait = 3'(ROM_WAIT);
            REG_IO:  w_wait = 3'(IO_WAIT);
            default: w_wait = 3'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_region     <= REG_NONE;
            r_cnt        <= 3'd0;
            r_master     <= MST_CPU;
            r_we         <= 1'b0;
            r_bus_addr   <= 16'h0000;
            r_bus_wdata  <= 8'h00;
            r_cpu_rdata  <= 8'h00;
            r_dma_rdata  <= 8'h00;
            r_ram_cs_n   <= 1'b1;
            r_rom_cs_n   <= 1'b1;
            r_io_cs_n    <= 1'b1;
            r_oe_n       <= 1'b1;
            r_we_n       <= 1'b1;
            r_cpu_ack    <= 1'b0;
            r_dma_ack    <= 1'b0;
            r_rom_wr_err <= 1'b0;
        end else begin
            r_cpu_ack    <= 1'b0;
            r_dma_ack    <= 1'b0;
            r_rom_wr_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_any) begin
                        r_master    <= w_grant_dma ? MST_DMA : MST_CPU;
                        r_we        <= w_req.we;
                        r_bus_addr  <= w_req.addr;
                        r_bus_wdata <= w_req.wdata;
                        r_state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    // Selects have had a full cycle to settle on bus_addr; latch them now.
                    // A ROM write keeps cs_n/we_n high but still runs the full cycle.
                    r_region   <= w_region;
                    r_cnt      <= w_wait;
                    r_ram_cs_n <= ~(w_region == REG_RAM);
                    r_rom_cs_n <= ~((w_region == REG_ROM) & ~r_we);
                    r_io_cs_n  <= ~(w_region == REG_IO);
                    r_oe_n     <= ~(~r_we & (w_region != REG_NONE));
                    r_we_n     <= ~(r_we & ((w_region == REG_RAM) | (w_region == REG_IO)));
                    r_state    <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (r_cnt == 3'd0) begin
                        r_oe_n       <= 1'b1;
                        r_we_n       <= 1'b1;
                        r_rom_wr_err <= r_we & (r_region == REG_ROM);
                        if (r_master == MST_DMA) begin
                            r_dma_ack <= 1'b1;
                            if (!r_we) r_dma_rdata <= w_rd_val;
                        end else begin
                            r_cpu_ack <= 1'b1;
                            if (!r_we) r_cpu_rdata <= w_rd_val;
                        end
                        r_state <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: begin
                    r_ram_cs_n <= 1'b1;
                    r_rom_cs_n <= 1'b1;
                    r_io_cs_n  <= 1'b1;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata  = r_cpu_rdata;
    assign dma_rdata  = r_dma_rdata;
    assign cpu_ack    = r_cpu_ack;
    assign dma_ack    = r_dma_ack;
    assign bus_addr   = r_bus_addr;
    assign bus_wdata  = r_bus_wdata;
    assign ram_cs_n   = r_ram_cs_n;
    assign rom_cs_n   = r_rom_cs_n;
    assign io_cs_n    = r_io_cs_n;
    assign bus_oe_n   = r_oe_n;
    assign bus_we_n   = r_we_n;
    assign rom_wr_err = r_rom_wr_err;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Bench for bus_cycle_controller: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized CPU/DMA traffic.
module tb_bus_cycle_controller;
    import bus_cycle_controller_pkg::*;

    localparam int RAM_W = 0;
    localparam int ROM_W = 1;
    localparam int IO_W  = 2;
    localparam logic [1:0] R_NONE = 2'd0;
    localparam logic [1:0] R_RAM  = 2'd1;
    localparam logic [1:0] R_ROM  = 2'd2;
    localparam logic [1:0] R_IO   = 2'd3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0;
    logic [7:0]  cpu_wdata = 8'h0;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [15:0] dma_addr = 16'h0;
    logic [7:0]  dma_wdata = 8'h0;
    logic [7:0]  bus_rdata = 8'h0;
    logic        force_unmapped = 1'b0;
    logic        rand_rdata = 1'b0;
    logic [7:0]  cpu_rdata, dma_rdata, bus_wdata;
    logic        cpu_ack, dma_ack;
    logic [15:0] bus_addr;
    logic        ram_sel_n, rom_sel_n, io_sel_n;
    logic        ram_cs_n, rom_cs_n, io_cs_n, bus_oe_n, bus_we_n, rom_wr_err;
    logic [1:0]  dbg_state;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Address decoder: IO window D000-DFFF plus page FFxx overlaps the ROM window E000-FFFF.
    assign io_sel_n  = force_unmapped | ~((bus_addr[15:12] == 4'hD) | (bus_addr[15:8] == 8'hFF));
    assign rom_sel_n = force_unmapped | ~(bus_addr[15:13] == 3'b111);
    assign ram_sel_n = force_unmapped | bus_addr[15];

    bus_cycle_controller #(.RAM_WAIT(RAM_W), .ROM_WAIT(ROM_W), .IO_WAIT(IO_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .ram_sel_n(ram_sel_n), .rom_sel_n(rom_sel_n), .io_sel_n(io_sel_n),
        .ram_cs_n(ram_cs_n), .rom_cs_n(rom_cs_n), .io_cs_n(io_cs_n),
        .bus_oe_n(bus_oe_n), .bus_we_n(bus_we_n), .rom_wr_err(rom_wr_err),
        .dbg_state(dbg_state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] region_of(input logic [15:0] a, input logic unm);
        if (unm) return R_NONE;
        if (a[15:12] == 4'hD || a[15:8] == 8'hFF) return R_IO;
        if (a >= 16'hE000) return R_ROM;
        if (a < 16'h8000) return R_RAM;
        return R_NONE;
    endfunction

    function automatic int wait_of(input logic [1:0] r);
        case (r)
            R_RAM:   return RAM_W;
            R_ROM:   return ROM_W;
            R_IO:    return IO_W;
            default: return 0;
        endcase
    endfunction

    // Reference model: one transaction at a time, t = cycles since its grant edge.
    bit          m_active = 0;
    int          m_t = 0, m_w = 0;
    logic        m_master = 1'b0, m_we = 1'b0, m_last = 1'b1;
    logic [1:0]  m_region = R_NONE;
    logic [15:0] e_addr = 16'h0;
    logic [7:0]  e_wdata = 8'h0, e_cpu_rd = 8'h0, e_dma_rd = 8'h0;

    initial begin
        logic       g;
        logic [7:0] rd;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_active = 0; m_t = 0; m_w = 0; m_last = 1'b1;
                e_addr = 16'h0; e_wdata = 8'h0; e_cpu_rd = 8'h0; e_dma_rd = 8'h0;
            end else if (m_active) begin
                if (m_t == 2 + m_w && !m_we) begin
                    rd = (m_region == R_NONE) ? 8'hFF : bus_rdata;
                    if (m_master) e_dma_rd = rd; else e_cpu_rd = rd;
                end
                m_t++;
                if (m_t == 4 + m_w) m_active = 0;
            end else if (cpu_req || dma_req) begin
                g = (cpu_req && dma_req) ? ~m_last : dma_req;
                m_last   = g;
                m_master = g;
                m_we     = g ? dma_we : cpu_we;
                e_addr   = g ? dma_addr : cpu_addr;
                e_wdata  = g ? dma_wdata : cpu_wdata;
                m_region = region_of(e_addr, force_unmapped);
                m_w      = wait_of(m_region);
                m_t      = 1;
                m_active = 1;
            end
        end
    end

    task automatic compare_outputs();
        logic acc, hold;
        acc  = m_active && m_t >= 2 && m_t <= 2 + m_w;
        hold = m_active && m_t == 3 + m_w;
        chk("ram_cs_n", ram_cs_n, !((acc || hold) && m_region == R_RAM));
        chk("rom_cs_n", rom_cs_n, !((acc || hold) && m_region == R_ROM && !m_we));
        chk("io_cs_n", io_cs_n, !((acc || hold) && m_region == R_IO));
        chk("bus_oe_n", bus_oe_n, !(acc && !m_we && m_region != R_NONE));
        chk("bus_we_n", bus_we_n, !(acc && m_we && (m_region == R_RAM || m_region == R_IO)));
        chk("cpu_ack", cpu_ack, hold && !m_master);
        chk("dma_ack", dma_ack, hold && m_master);
        chk("rom_wr_err", rom_wr_err, hold && m_we && m_region == R_ROM);
        chk("bus_addr", bus_addr, e_addr);
        chk("bus_wdata", bus_wdata, e_wdata);
        chk("cpu_rdata", cpu_rdata, e_cpu_rd);
        chk("dma_rdata", dma_rdata, e_dma_rd);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            compare_outputs();
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdata) bus_rdata = 8'($urandom);
        end
    end

    task automatic set_master(input logic is_dma, input logic req, input logic we,
                              input logic [15:0] addr, input logic [7:0] wd);
        if (is_dma) begin
            dma_req = req; dma_we = we; dma_addr = addr; dma_wdata = wd;
        end else begin
            cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        end
    endtask

    // One isolated transaction; cycle 0 is the IDLE cycle in which the request is first seen.
    task automatic run_one(input logic is_dma, input logic we, input logic [15:0] addr,
                           input logic [7:0] wd, input logic [7:0] rd,
                           output int ack_cyc, output int err_cyc, output int n_ram,
                           output int n_rom, output int n_io, output int n_oe,
                           output int n_we, output int n_wrong, output int n_bad);
        ack_cyc = -1; err_cyc = -1; n_ram = 0; n_rom = 0; n_io = 0;
        n_oe = 0; n_we = 0; n_wrong = 0; n_bad = 0;
        bus_rdata = rd;
        @(posedge clk);
        #1;
        set_master(is_dma, 1'b1, we, addr, wd);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (!ram_cs_n) n_ram++;
            if (!rom_cs_n) n_rom++;
            if (!io_cs_n)  n_io++;
            if (!bus_oe_n) n_oe++;
            if (!bus_we_n) n_we++;
            if (rom_wr_err) err_cyc = n;
            if (is_dma ? cpu_ack : dma_ack) n_wrong++;
            if (n >= 1 && (bus_addr !== addr || (we && bus_wdata !== wd))) n_bad++;
            if (is_dma ? dma_ack : cpu_ack) begin
                ack_cyc = n;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (is_dma) dma_req = 1'b0; else cpu_req = 1'b0;
    endtask

    function automatic logic [15:0] rand_addr();
        case ($urandom_range(0, 4))
            0:       return {1'b0, 15'($urandom)};
            1:       return {4'hD, 12'($urandom)};
            2:       return {8'hFF, 8'($urandom)};
            3:       return {4'hE, 12'($urandom)};
            default: return 16'h8000 + 16'($urandom_range(0, 16'h4FFF));
        endcase
    endfunction

    task automatic new_req(input logic is_dma);
        set_master(is_dma, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
    endtask

    task automatic drive_master(input logic is_dma, input int n_txn);
        int   done = 0;
        int   guard = 0;
        logic ack, req;
        while (done < n_txn && guard < 8000) begin
            @(posedge clk);
            #1;
            guard++;
            ack = is_dma ? dma_ack : cpu_ack;
            req = is_dma ? dma_req : cpu_req;
            if (ack) begin
                done++;
                if (done < n_txn && $urandom_range(0, 2) != 0) new_req(is_dma);
                else if (is_dma) dma_req = 1'b0; else cpu_req = 1'b0;
            end else if (!req) begin
                if ($urandom_range(0, 3) == 0) new_req(is_dma);
            end else if ($urandom_range(0, 99) == 0) begin
                // Protocol violation: drop a request that may already be in flight.
                if (is_dma) dma_req = 1'b0; else cpu_req = 1'b0;
            end
        end
        if (is_dma) dma_req = 1'b0; else cpu_req = 1'b0;
        chk(is_dma ? "random_dma_done" : "random_cpu_done", done, n_txn);
    endtask

    initial begin
        int ack_cyc, err_cyc, n_ram, n_rom, n_io, n_oe, n_we, n_wrong, n_bad;
        int n_acks, both;
        int ack_at[4];
        logic [3:0] who;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_cs", {ram_cs_n, rom_cs_n, io_cs_n}, 3'b111);
        chk("reset_strobes", {bus_oe_n, bus_we_n}, 2'b11);
        chk("reset_pulses", {cpu_ack, dma_ack, rom_wr_err}, 3'b000);
        chk("reset_bus", {bus_addr, bus_wdata}, 24'h0);
        chk("reset_rdata", {cpu_rdata, dma_rdata}, 16'h0);
        chk("reset_state", dbg_state, ST_IDLE);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Both masters held: round-robin from reset, RAM reads back to back.
        cpu_addr = 16'h0010; cpu_we = 1'b0; dma_addr = 16'h0020; dma_we = 1'b0;
        bus_rdata = 8'h11;
        n_acks = 0; both = 0; who = 4'b0;
        ack_at = '{-1, -1, -1, -1};
        @(posedge clk);
        #1;
        cpu_req = 1'b1; dma_req = 1'b1;
        for (int n = 0; n < 40 && n_acks < 4; n++) begin
            @(negedge clk);
            if (cpu_ack && dma_ack) both++;
            if (cpu_ack || dma_ack) begin
                ack_at[n_acks] = n;
                who[n_acks] = dma_ack;
                n_acks++;
            end
        end
        @(posedge clk);
        #1;
        cpu_req = 1'b0; dma_req = 1'b0;
        chk("rr_ack_count", n_acks, 4);
        chk("rr_order", who, 4'b1010);
        chk("rr_double_ack", both, 0);
        chk("rr_ack0", ack_at[0], 3);
        chk("rr_ack1", ack_at[1], 7);
        chk("rr_ack2", ack_at[2], 11);
        chk("rr_ack3", ack_at[3], 15);

        // CPU read from RAM.
        run_one(1'b0, 1'b0, 16'h0100, 8'h00, 8'h5A,
                ack_cyc, err_cyc, n_ram, n_rom, n_io, n_oe, n_we, n_wrong, n_bad);
        chk("t1_ack_cycle", ack_cyc, 3);
        chk("t1_oe_cycles", n_oe, 1);
        chk("t1_ram_cs_cycles", n_ram, 2);
        chk("t1_we_cycles", n_we, 0);
        chk("t1_cpu_rdata", cpu_rdata, 8'h5A);

        // DMA write to IO.
        run_one(1'b1, 1'b1, 16'hD004, 8'hC3, 8'h00,
                ack_cyc, err_cyc, n_ram, n_rom, n_io, n_oe, n_we, n_wrong, n_bad);
        chk("t2_ack_cycle", ack_cyc, 5);
        chk("t2_we_cycles", n_we, 3);
        chk("t2_io_cs_cycles", n_io, 4);
        chk("t2_oe_cycles", n_oe, 0);
        chk("t2_bus_held", n_bad, 0);
        chk("t2_cpu_ack_none", n_wrong, 0);
        chk("t2_cpu_rdata_kept", cpu_rdata, 8'h5A);

        // CPU write to ROM: error pulse, no device strobes.
        run_one(1'b0, 1'b1, 16'hF000, 8'h99, 8'h00,
                ack_cyc, err_cyc, n_ram, n_rom, n_io, n_oe, n_we, n_wrong, n_bad);
        chk("t3_ack_cycle", ack_cyc, 4);
        chk("t3_err_cycle", err_cyc, 4);
        chk("t3_rom_cs_cycles", n_rom, 0);
        chk("t3_we_cycles", n_we, 0);
        chk("t3_ram_io_cs", n_ram + n_io, 0);

        // Page FFxx decodes as both ROM and IO; IO wins.
        run_one(1'b0, 1'b0, 16'hFF10, 8'h00, 8'hA7,
                ack_cyc, err_cyc, n_ram, n_rom, n_io, n_oe, n_we, n_wrong, n_bad);
        chk("prio_ack_cycle", ack_cyc, 5);
        chk("prio_io_cs_cycles", n_io, 4);
        chk("prio_rom_cs_cycles", n_rom, 0);
        chk("prio_cpu_rdata", cpu_rdata, 8'hA7);

        // Unmapped read.
        force_unmapped = 1'b1;
        run_one(1'b0, 1'b0, 16'h0100, 8'h00, 8'h33,
                ack_cyc, err_cyc, n_ram, n_rom, n_io, n_oe, n_we, n_wrong, n_bad);
        force_unmapped = 1'b0;
        chk("t6_ack_cycle", ack_cyc, 3);
        chk("t6_strobes", n_ram + n_rom + n_io + n_oe + n_we, 0);
        chk("t6_cpu_rdata", cpu_rdata, 8'hFF);

        // Reset in the middle of an IO read access.
        @(posedge clk);
        #1;
        set_master(1'b0, 1'b1, 1'b0, 16'hD010, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_io_cs_before", io_cs_n, 1'b0);
        reset_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        chk("t5_cs_released", {ram_cs_n, rom_cs_n, io_cs_n}, 3'b111);
        chk("t5_strobes_released", {bus_oe_n, bus_we_n}, 2'b11);
        n_acks = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (cpu_ack || dma_ack) n_acks++;
        end
        chk("t5_no_ack", n_acks, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        run_one(1'b0, 1'b0, 16'h0200, 8'h00, 8'h77,
                ack_cyc, err_cyc, n_ram, n_rom, n_io, n_oe, n_we, n_wrong, n_bad);
        chk("t5_after_ack_cycle", ack_cyc, 3);
        chk("t5_after_rdata", cpu_rdata, 8'h77);

        // Random traffic from both masters, checked by the model every cycle.
        rand_rdata = 1'b1;
        fork
            drive_master(1'b0, 150);
            drive_master(1'b1, 150);
        join
        rand_rdata = 1'b0;
        repeat (10) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
